// File: rtl/rcvr_pkg.sv
// Shared constants and state encoding for the receiver-bank arbiter.
package rcvr_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned RCVR_NUM_CH = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StGrant   = ST_GRANT,
        StPresent = ST_PRESENT
    } state_e;

endpackage

// File: rtl/rcvr_rr_pick.sv
// Combinational round-robin selector: first set request after last_i, wrapping at NUM_CH.
module rcvr_rr_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic              any_o,
    output logic [CH_W-1:0]   idx_o
);

    logic [CH_W:0]   cand_sum;
    logic [CH_W-1:0] cand;

    // Walk candidates last+1 .. last+NUM_CH (mod NUM_CH); first hit wins.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand_sum = {1'b0, last_i} + (CH_W+1)'(k);
            if (cand_sum >= (CH_W+1)'(NUM_CH)) begin
                cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
            end
            cand = cand_sum[CH_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/rcvr_arbiter.sv
// Round-robin arbiter sharing one byte sink between NUM_CH serial receivers.
// Optional per-channel overrun counters are enabled with RCVR_ARBITER_OVR_CNT_EN.
module rcvr_arbiter
    import rcvr_pkg::*;
#(
    parameter int unsigned NUM_CH = RCVR_NUM_CH,
    parameter int unsigned CH_W   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_ready_i,
    input  logic [NUM_CH-1:0]        ch_overrun_i,
    input  logic [BYTE_W*NUM_CH-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_reading_o,
    output logic                     out_valid_o,
    output logic [BYTE_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_chan_o,
    output logic                     out_ovr_o,
    input  logic                     out_ack_i
`ifdef RCVR_ARBITER_OVR_CNT_EN
    ,
    input  logic                     ovr_clr_i,
    output logic [BYTE_W*NUM_CH-1:0] ovr_cnt_o
`endif
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     grant_idx_q, grant_idx_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0]   ch_reading_q, ch_reading_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_chan_q, out_chan_d;
    logic                out_ovr_q, out_ovr_d;
    logic                pick_any;
    logic [CH_W-1:0]     pick_idx;
    logic [BYTE_W-1:0]   ch_byte [NUM_CH];

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_unpack
        assign ch_byte[g] = ch_data_i[g*BYTE_W +: BYTE_W];
    end

    rcvr_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req_i  (ch_ready_i),
        .last_i (ptr_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic: GRANT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pick_any) state_d = StGrant;
            StGrant:   state_d = StPresent;
            StPresent: if (out_ack_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output/datapath next values; ch_reading is registered so it is high only during GRANT.
    always_comb begin
        grant_idx_d  = grant_idx_q;
        ptr_d        = ptr_q;
        ch_reading_d = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_ovr_d    = out_ovr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_idx_d  = pick_idx;
                    ptr_d        = pick_idx;
                    ch_reading_d = NUM_CH'(1) << pick_idx;
                end
            end
            StGrant: begin
                out_data_d  = ch_byte[grant_idx_q];
                out_ovr_d   = ch_overrun_i[grant_idx_q];
                out_chan_d  = grant_idx_q;
                out_valid_d = 1'b1;
            end
            StPresent: begin
                if (out_ack_i) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; pointer resets to NUM_CH-1 so channel 0 is searched first.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_idx_q  <= '0;
            ptr_q        <= CH_W'(NUM_CH - 1);
            ch_reading_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_ovr_q    <= 1'b0;
        end else begin
            grant_idx_q  <= grant_idx_d;
            ptr_q        <= ptr_d;
            ch_reading_q <= ch_reading_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_ovr_q    <= out_ovr_d;
        end
    end

    assign ch_reading_o = ch_reading_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_chan_o   = out_chan_q;
    assign out_ovr_o    = out_ovr_q;

`ifdef RCVR_ARBITER_OVR_CNT_EN
    logic [BYTE_W-1:0] ovr_cnt_q [NUM_CH];

    // Saturating overrun counters; clear wins over increment.
    always_ff @(posedge clock) begin
        if (reset || ovr_clr_i) begin
            for (int i = 0; i < int'(NUM_CH); i++) ovr_cnt_q[i] <= '0;
        end else if (state_q == StGrant && ch_overrun_i[grant_idx_q] &&
                     ovr_cnt_q[grant_idx_q] != '1) begin
            ovr_cnt_q[grant_idx_q] <= ovr_cnt_q[grant_idx_q] + BYTE_W'(1);
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt_out
        assign ovr_cnt_o[g*BYTE_W +: BYTE_W] = ovr_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rcvr_arbiter.sv
// Directed self-checking bench for rcvr_arbiter with a simple receiver model.
module tb_rcvr_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_overrun;
    logic [31:0] ch_data;
    logic [3:0]  ch_reading;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ovr;
    logic        out_ack;
    logic [3:0]  sticky;
    int          n_checks = 0;
    int          n_errors = 0;
    int          idx;
    int          n_grants;
`ifdef RCVR_ARBITER_OVR_CNT_EN
    logic        ovr_clr;
    logic [31:0] ovr_cnt;
`endif

    rcvr_arbiter #(
        .NUM_CH (4),
        .CH_W   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ch_ready_i   (ch_ready),
        .ch_overrun_i (ch_overrun),
        .ch_data_i    (ch_data),
        .ch_reading_o (ch_reading),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_chan_o   (out_chan),
        .out_ovr_o    (out_ovr),
        .out_ack_i    (out_ack)
`ifdef RCVR_ARBITER_OVR_CNT_EN
        ,
        .ovr_clr_i    (ovr_clr),
        .ovr_cnt_o    (ovr_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock; sample just after the edge, then the receiver drops ready on a reading pulse.
    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ch_reading[i] && !sticky[i]) ch_ready[i] = 1'b0;
        end
    endtask

    task automatic wait_grant(input int budget, output int gidx);
        gidx = -1;
        for (int c = 0; c < budget && gidx < 0; c++) begin
            step();
            for (int i = 0; i < 4; i++) if (ch_reading[i]) gidx = i;
        end
        if (gidx >= 0) check("reading_onehot", 32'($countones(ch_reading)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ch_ready = '0; ch_overrun = '0; ch_data = '0;
        out_ack = 1'b0; sticky = '0;
`ifdef RCVR_ARBITER_OVR_CNT_EN
        ovr_clr = 1'b0;
`endif
        step(); step();
        check("rst_reading", 32'(ch_reading), 32'h0);
        check("rst_valid",   32'(out_valid),  32'h0);
        check("rst_data",    32'(out_data),   32'h0);
        check("rst_chan",    32'(out_chan),   32'h0);
        check("rst_ovr",     32'(out_ovr),    32'h0);
        reset = 1'b0;
        step();
        check("idle_valid", 32'(out_valid), 32'h0);

        // Single byte on channel 0, ack held high.
        out_ack = 1'b1;
        ch_data = 32'h0000_003C;
        ch_ready = 4'b0001;
        step();
        check("t1_reading", 32'(ch_reading), 32'h1);
        check("t1_valid_grant", 32'(out_valid), 32'h0);
        step();
        check("t1_reading_off", 32'(ch_reading), 32'h0);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data",  32'(out_data),  32'h3C);
        check("t1_chan",  32'(out_chan),  32'h0);
        check("t1_ovr",   32'(out_ovr),   32'h0);
        step();
        check("t1_ack_valid", 32'(out_valid), 32'h0);

        // All channels continuously ready after a fresh reset: strict rotation 0,1,2,3,0.
        reset = 1'b1; step(); reset = 1'b0;
        ch_data = 32'h1312_1110;
        sticky = 4'b1111; ch_ready = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(4, idx);
            check("t2_grant", 32'(idx), 32'(g % 4));
            step();
            check("t2_valid", 32'(out_valid), 32'h1);
            check("t2_data",  32'(out_data),  32'h10 + 32'(g % 4));
            check("t2_chan",  32'(out_chan),  32'(g % 4));
        end
        sticky = '0; ch_ready = '0;
        step();

        // Channel 2 with overrun set.
        ch_data = 32'h00A5_0000;
        ch_overrun = 4'b0100;
        ch_ready = 4'b0100;
        wait_grant(4, idx);
        check("t3_grant", 32'(idx), 32'd2);
        step();
        check("t3_valid", 32'(out_valid), 32'h1);
        check("t3_chan",  32'(out_chan),  32'h2);
        check("t3_ovr",   32'(out_ovr),   32'h1);
        check("t3_data",  32'(out_data),  32'hA5);
        ch_overrun = '0;
        step();
`ifdef RCVR_ARBITER_OVR_CNT_EN
        check("t3_cnt2", 32'(ovr_cnt[23:16]), 32'h1);
        check("t3_cnt0", 32'(ovr_cnt[7:0]),   32'h0);
`endif

        // Back-pressure: sink stalls 20 cycles while channel 1 becomes ready.
        out_ack = 1'b0;
        ch_data = 32'h7700_0000;
        ch_ready = 4'b1000;
        wait_grant(4, idx);
        check("t4_grant3", 32'(idx), 32'd3);
        step();
        check("t4_valid", 32'(out_valid), 32'h1);
        check("t4_data",  32'(out_data),  32'h77);
        ch_data = 32'h7700_4100;
        ch_ready[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check("t4_hold", {19'h0, ch_reading, out_valid, out_data}, {19'h0, 4'b0000, 1'b1, 8'h77});
        end
        out_ack = 1'b1;
        wait_grant(2, idx);
        check("t4_grant1", 32'(idx), 32'd1);
        step();
        check("t4_data1", 32'(out_data), 32'h41);
        check("t4_chan1", 32'(out_chan), 32'h1);
        step();

        // Reset during GRANT, then channel 0 must be searched first.
        ch_ready = 4'b0100;
        wait_grant(4, idx);
        check("t5_grant2", 32'(idx), 32'd2);
        reset = 1'b1;
        step();
        check("t5_reading", 32'(ch_reading), 32'h0);
        check("t5_valid",   32'(out_valid),  32'h0);
        check("t5_data",    32'(out_data),   32'h0);
        reset = 1'b0;
        ch_data = 32'hD000_00E0;
        ch_ready = 4'b1001;
        wait_grant(1, idx);
        check("t5_first", 32'(idx), 32'd0);
        step();
        check("t5_data0", 32'(out_data), 32'hE0);
        step();
        wait_grant(4, idx);
        check("t5_second", 32'(idx), 32'd3);
        step();
        check("t5_data3", 32'(out_data), 32'hD0);
        step();

`ifdef RCVR_ARBITER_OVR_CNT_EN
        // 300 overrun captures on channel 3 saturate its counter; clear zeroes all.
        n_grants = 0;
        sticky = 4'b1000; ch_ready = 4'b1000; ch_overrun = 4'b1000;
        for (int c = 0; c < 300; c++) begin
            wait_grant(4, idx);
            if (idx == 3) n_grants++;
        end
        check("t6_grants", 32'(n_grants), 32'd300);
        sticky = '0; ch_ready = '0; ch_overrun = '0;
        step(); step();
        check("t6_sat", 32'(ovr_cnt[31:24]), 32'hFF);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("t6_clr", ovr_cnt, 32'h0);
`else
        n_grants = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rcvr_arbiter.md
Name: rcvr_arbiter

Overview:
- Shares one byte consumer between NUM_CH serial receiver channels.
- Each channel presents ready, overrun and an 8-bit data_out, and clears ready/overrun on a one-cycle reading pulse.
- The arbiter polls ready flags round-robin, pulses the granted channel's reading, captures its byte and overrun status, and presents them on a single valid/ack output port.
- Sits between the receiver bank and the downstream byte sink.

Parameters:
- NUM_CH, 4, number of receiver channels (2..8).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ch_ready  in  NUM_CH  per-channel byte-available flag.
- ch_overrun  in  NUM_CH  per-channel overrun flag.
- ch_data  in  8*NUM_CH  per-channel byte; channel i occupies bits [8i+7:8i].
- ch_reading  out  NUM_CH  one-hot reading pulse to the granted channel.
- out_valid  out  1  output byte valid.
- out_data  out  8  captured byte.
- out_chan  out  CH_W  source channel of out_data.
- out_ovr  out  1  source channel had overrun set at capture.
- out_ack  in  1  sink accepts the byte.

Behaviour:
- Interface: reset is synchronous, active-high, named reset; clock is clock. All state updates on posedge clock.
- Reset values:
  - state=IDLE, ch_reading=0, out_valid=0, out_data=0, out_chan=0, out_ovr=0.
  - Last-grant pointer = NUM_CH-1, so channel 0 is searched first.
- FSM states: IDLE, GRANT, PRESENT.
- IDLE:
  - If any ch_ready is set, select the first set channel searching from pointer+1 upward with wrap-around modulo NUM_CH.
  - Register the index into grant_idx and pointer, then go to GRANT.
  - With no ready, stay in IDLE.
- GRANT (exactly one cycle):
  - ch_reading is a registered output, equal to 1<<grant_idx during this cycle only; all other bits 0.
  - At the end of the cycle, latch ch_data[grant_idx] into out_data, ch_overrun[grant_idx] into out_ovr, and grant_idx into out_chan.
  - Set out_valid and go to PRESENT.
- PRESENT:
  - out_valid=1; out_data, out_chan and out_ovr are held stable.
  - out_ack=1 clears out_valid and returns to IDLE.
  - With out_ack=0, hold indefinitely; receivers may overrun meanwhile, and that is reported on the next capture.
- Minimum service time: 3 cycles per byte (IDLE, GRANT, PRESENT with immediate ack).
- The receiver clears ready at the edge ending GRANT, so IDLE never re-grants on a stale ready.
- Receiver completes a new byte in the same cycle as reading:
  - Receiver ready stays 1 and its data_out updates.
  - The arbiter has already captured the old byte; the new byte is served on a later round.
- out_ack outside PRESENT is ignored.
- ch_ready bits at or above NUM_CH do not exist; selection never yields an index >= NUM_CH.
- Reset mid-operation (any state): return to IDLE the next cycle, drop any captured byte, deassert ch_reading and out_valid.
- Fairness: a continuously ready channel waits at most NUM_CH-1 other grants.

Optional Feature:
- Macro RCVR_ARBITER_OVR_CNT_EN.
- When defined:
  - Adds output ovr_cnt (8*NUM_CH bits): per-channel 8-bit saturating counters (255 max).
  - A counter increments in each GRANT cycle where the granted channel's ch_overrun=1.
  - Adds input ovr_clr (1 bit); ovr_clr=1 zeroes all counters and has priority over increment.
  - Counters reset to 0.
- When undefined: neither port exists, and the base behaviour is unchanged.

Decomposition:
- Package rcvr_pkg holds:
  - state encoding constants ST_IDLE=0, ST_GRANT=1, ST_PRESENT=2 (2-bit);
  - BYTE_W=8;
  - default NUM_CH=4.
- One sub-module, rcvr_rr_pick:
  - combinational round-robin selector;
  - inputs: request vector and last pointer;
  - outputs: any flag and chosen index;
  - instantiated once in IDLE selection.

Test Plan:
- Reset, then ch_ready=4'b0001, ch_data[7:0]=8'h3C, out_ack held 1:
  - ch_reading=4'b0001 exactly one cycle;
  - then out_valid=1 with out_data=8'h3C, out_chan=0, out_ovr=0.
- All four channels ready continuously, data 8'h10..8'h13, out_ack=1: grants in order 0,1,2,3,0 and out_data sequence 10,11,12,13; no channel granted twice before the others.
- Channel 2 ready with ch_overrun[2]=1, data 8'hA5: out_chan=2, out_ovr=1, out_data=8'hA5.
- out_ack held 0 for 20 cycles while channel 1 becomes ready:
  - out_valid and out_data stay constant;
  - ch_reading stays 0 until ack, then channel 1 is granted within 2 cycles.
- Reset asserted during GRANT: next cycle ch_reading=0, out_valid=0, state IDLE; channel 0 is searched first on the following request.
- With RCVR_ARBITER_OVR_CNT_EN defined: 300 overrun captures on channel 3 leave ovr_cnt[31:24]=8'hFF; ovr_clr pulse then gives all counters 0.
